// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard, stall, flush and PC-select control for an in-order
//   IF/ID/RR/EXE/WB pipeline.
//   - Tracks outstanding register writes in a 32-entry pending scoreboard
//     (x0 never pending).
//   - Stalls the front end on RAW hazards or a busy EXE stage.
//   - Handles EXE branch redirects in the same cycle.
//   - Sequences exceptions RUN -> (DRAIN while EXE busy) -> REDIRECT -> RUN.
//   - Counts stalled RR cycles in a saturating 32-bit counter.
//
// Ports
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   rr_*_i                    instruction at RR: valid, sources, use flags,
//                             destination, write enable
//   exe_busy_i                EXE holds a multicycle operation
//   wb_valid_i/wb_we_i/wb_rd_i  write-back this cycle
//   branch_taken_i, xcpt_i    EXE redirect / exception
//   stall_{if,id,rr,exe}_o    hold pipeline registers
//   flush_o                   invalidate IF/ID/RR
//   issue_o                   RR instruction enters EXE this cycle
//   next_pc_sel_o             00 PC+4, 01 branch, 10 exception vector, 11 hold
//   stall_cycles_o            stalled-RR cycle counter (saturating)
//
// Configuration
//   PIPECTRL_WB_BYPASS_EN     when defined, a source being written back in the
//                             current cycle is not treated as pending.
// ---------------------------------------------------------------------------
module pipeline_ctrl (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        rr_valid_i,
    input  logic [4:0]  rr_rs1_i,
    input  logic [4:0]  rr_rs2_i,
    input  logic        rr_use_rs1_i,
    input  logic        rr_use_rs2_i,
    input  logic [4:0]  rr_rd_i,
    input  logic        rr_we_i,
    input  logic        exe_busy_i,
    input  logic        wb_valid_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        branch_taken_i,
    input  logic        xcpt_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_rr_o,
    output logic        stall_exe_o,
    output logic        flush_o,
    output logic        issue_o,
    output logic [1:0]  next_pc_sel_o,
    output logic [31:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_XVEC   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic        wb_write_s;
    logic        rs1_pend_s;
    logic        rs2_pend_s;
    logic        hazard_s;
    logic        front_stall_s;

    assign wb_write_s = wb_valid_i & wb_we_i;

    // RAW hazard detection against the pending scoreboard
    always_comb begin
        rs1_pend_s = pend_q[rr_rs1_i];
        rs2_pend_s = pend_q[rr_rs2_i];
`ifdef PIPECTRL_WB_BYPASS_EN
        // The register file writes through, so a value landing this cycle
        // is readable by RR in the same cycle.
        if (wb_write_s && (wb_rd_i == rr_rs1_i)) begin
            rs1_pend_s = 1'b0;
        end else begin
            rs1_pend_s = pend_q[rr_rs1_i];
        end
        if (wb_write_s && (wb_rd_i == rr_rs2_i)) begin
            rs2_pend_s = 1'b0;
        end else begin
            rs2_pend_s = pend_q[rr_rs2_i];
        end
`endif
        hazard_s = rr_valid_i & ((rr_use_rs1_i & rs1_pend_s) |
                                 (rr_use_rs2_i & rs2_pend_s));
    end

    // Control outputs and next-state selection
    always_comb begin
        state_d       = state_q;
        front_stall_s = 1'b0;
        issue_o       = 1'b0;
        flush_o       = 1'b0;
        next_pc_sel_o = PC_SEQ;
        case (state_q)
            RUN: begin
                front_stall_s = rr_valid_i & (hazard_s | exe_busy_i) & ~branch_taken_i;
                issue_o       = rr_valid_i & ~hazard_s & ~exe_busy_i &
                                ~branch_taken_i & ~xcpt_i;
                // Exception outranks a branch resolved in the same cycle.
                if (xcpt_i) begin
                    next_pc_sel_o = PC_HOLD;
                    state_d       = exe_busy_i ? DRAIN : REDIRECT;
                end else if (branch_taken_i) begin
                    next_pc_sel_o = PC_BRANCH;
                    flush_o       = 1'b1;
                end else begin
                    next_pc_sel_o = PC_SEQ;
                end
            end
            DRAIN: begin
                front_stall_s = 1'b1;
                next_pc_sel_o = PC_HOLD;
                state_d       = exe_busy_i ? DRAIN : REDIRECT;
            end
            REDIRECT: begin
                next_pc_sel_o = PC_XVEC;
                flush_o       = 1'b1;
                state_d       = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign stall_if_o     = front_stall_s;
    assign stall_id_o     = front_stall_s;
    assign stall_rr_o     = front_stall_s;
    assign stall_exe_o    = exe_busy_i;
    assign stall_cycles_o = stall_cycles_q;

    // Scoreboard update: write-back clears first so a same-cycle issue re-sets
    always_comb begin
        pend_d = pend_q;
        if (wb_write_s) begin
            pend_d[wb_rd_i] = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (issue_o && rr_we_i && (rr_rd_i != 5'd0)) begin
            pend_d[rr_rd_i] = 1'b1;
        end else begin
            pend_d[rr_rd_i] = pend_d[rr_rd_i];
        end
        pend_d[0] = 1'b0;
    end

    // Saturating stall counter
    always_comb begin
        if (front_stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= RUN;
            pend_q         <= 32'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed scenarios followed by random traffic, every cycle compared
//   against a behavioural model of the control rules.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        rr_valid_i, rr_use_rs1_i, rr_use_rs2_i, rr_we_i;
    logic [4:0]  rr_rs1_i, rr_rs2_i, rr_rd_i;
    logic        exe_busy_i, wb_valid_i, wb_we_i;
    logic [4:0]  wb_rd_i;
    logic        branch_taken_i, xcpt_i;
    logic        stall_if_o, stall_id_o, stall_rr_o, stall_exe_o;
    logic        flush_o, issue_o;
    logic [1:0]  next_pc_sel_o;
    logic [31:0] stall_cycles_o;

    pipeline_ctrl dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .rr_valid_i     (rr_valid_i),
        .rr_rs1_i       (rr_rs1_i),
        .rr_rs2_i       (rr_rs2_i),
        .rr_use_rs1_i   (rr_use_rs1_i),
        .rr_use_rs2_i   (rr_use_rs2_i),
        .rr_rd_i        (rr_rd_i),
        .rr_we_i        (rr_we_i),
        .exe_busy_i     (exe_busy_i),
        .wb_valid_i     (wb_valid_i),
        .wb_we_i        (wb_we_i),
        .wb_rd_i        (wb_rd_i),
        .branch_taken_i (branch_taken_i),
        .xcpt_i         (xcpt_i),
        .stall_if_o     (stall_if_o),
        .stall_id_o     (stall_id_o),
        .stall_rr_o     (stall_rr_o),
        .stall_exe_o    (stall_exe_o),
        .flush_o        (flush_o),
        .issue_o        (issue_o),
        .next_pc_sel_o  (next_pc_sel_o),
        .stall_cycles_o (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    localparam int M_RUN = 0, M_DRAIN = 1, M_REDIR = 2;
    int          m_mode;
    bit          m_pend [32];
    logic [31:0] m_cnt;
    // Expected outputs for the current cycle
    bit          e_front, e_issue, e_flush;
    logic [1:0]  e_sel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_RUN;
        m_cnt  = 32'd0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    function automatic bit src_pending(input logic [4:0] r);
        bit p;
        p = m_pend[r];
`ifdef PIPECTRL_WB_BYPASS_EN
        if (wb_valid_i && wb_we_i && wb_rd_i == r) p = 1'b0;
`endif
        return p;
    endfunction

    task automatic model_eval();
        bit haz;
        haz = rr_valid_i && ((rr_use_rs1_i && src_pending(rr_rs1_i)) ||
                             (rr_use_rs2_i && src_pending(rr_rs2_i)));
        e_front = 1'b0; e_issue = 1'b0; e_flush = 1'b0; e_sel = 2'd0;
        if (m_mode == M_RUN) begin
            e_front = rr_valid_i && (haz || exe_busy_i) && !branch_taken_i;
            e_issue = rr_valid_i && !haz && !exe_busy_i && !branch_taken_i && !xcpt_i;
            if (xcpt_i) e_sel = 2'd3;
            else if (branch_taken_i) begin e_sel = 2'd1; e_flush = 1'b1; end
        end else if (m_mode == M_DRAIN) begin
            e_front = 1'b1; e_sel = 2'd3;
        end else begin
            e_sel = 2'd2; e_flush = 1'b1;
        end
    endtask

    task automatic model_step();
        if (wb_valid_i && wb_we_i) m_pend[wb_rd_i] = 1'b0;
        if (e_issue && rr_we_i && rr_rd_i != 5'd0) m_pend[rr_rd_i] = 1'b1;
        if (e_front && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        case (m_mode)
            M_RUN:   if (xcpt_i) m_mode = exe_busy_i ? M_DRAIN : M_REDIR;
            M_DRAIN: if (!exe_busy_i) m_mode = M_REDIR;
            default: m_mode = M_RUN;
        endcase
    endtask

    task automatic check_outputs();
        model_eval();
        check_eq("stall_if",  {31'd0, stall_if_o},  {31'd0, e_front});
        check_eq("stall_id",  {31'd0, stall_id_o},  {31'd0, e_front});
        check_eq("stall_rr",  {31'd0, stall_rr_o},  {31'd0, e_front});
        check_eq("stall_exe", {31'd0, stall_exe_o}, {31'd0, exe_busy_i});
        check_eq("flush",     {31'd0, flush_o},     {31'd0, e_flush});
        check_eq("issue",     {31'd0, issue_o},     {31'd0, e_issue});
        check_eq("pc_sel",    {30'd0, next_pc_sel_o}, {30'd0, e_sel});
        check_eq("stall_cnt", stall_cycles_o, m_cnt);
    endtask

    task automatic drive(input bit v, input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit we, input bit busy,
                         input bit wbv, input logic [4:0] wbrd,
                         input bit br, input bit xc);
        rr_valid_i = v;  rr_rs1_i = rs1; rr_use_rs1_i = u1;
        rr_rs2_i = rs2;  rr_use_rs2_i = u2; rr_rd_i = rd; rr_we_i = we;
        exe_busy_i = busy; wb_valid_i = wbv; wb_we_i = wbv; wb_rd_i = wbrd;
        branch_taken_i = br; xcpt_i = xc;
    endtask

    // One cycle: inputs already driven after the falling edge
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic idle();
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    endtask

    initial begin
        rstn_i = 1'b0;
        idle();
        model_reset();
        @(negedge clk_i);
        #1 check_outputs();            // reset state, all inputs 0
        @(negedge clk_i);
        rstn_i = 1'b1;

        // RAW on x5, cleared by write-back
        drive(1, 5'd1, 1, 5'd2, 0, 5'd5, 1, 0, 0, 5'd0, 0, 0); cycle();
        drive(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 5'd0, 0, 0); cycle();
        drive(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1, 5'd5, 0, 0); cycle();
        drive(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 5'd0, 0, 0); cycle();
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd6, 0, 0); cycle();

        // x0 destination never becomes pending
        drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 5'd0, 0, 0); cycle();
        drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 5'd0, 0, 0); cycle();

        // Branch while RR has a hazard on x7
        drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 5'd0, 0, 0); cycle();
        drive(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 0); cycle();
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 5'd7, 0, 0); cycle();

        // Exception with EXE busy for 3 cycles, then redirect
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 1); cycle();
        drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 1, 1); cycle();
        drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0); cycle();
        drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0); cycle();
        drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 1, 1); cycle();
        idle(); cycle();

        // Exception and branch together, EXE idle
        drive(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 5'd0, 1, 1); cycle();
        idle(); cycle();
        idle(); cycle();

        // Counter saturation from a preloaded value
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cycles_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0); cycle();
        end
        idle(); cycle();

        // Reset in the middle of DRAIN
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 1); cycle();
        drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0, 0); cycle();
        #2 rstn_i = 1'b0;
        idle();
        model_reset();
        #1 check_outputs();
        @(negedge clk_i);
        rstn_i = 1'b1;
        idle(); cycle();
        idle(); cycle();

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(3, 0) != 0,
                  5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                  5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                  5'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                  $urandom_range(3, 0) == 0,
                  $urandom_range(2, 0) == 0, 5'($urandom_range(7, 0)),
                  $urandom_range(19, 0) == 0, $urandom_range(29, 0) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports rr_valid_i in 1, rr_rs1_i in 5, rr_rs2_i in 5, rr_use_rs1_i in 1, rr_use_rs2_i in 1, rr_rd_i in 5, rr_we_i in 1: instruction at RR stage and its register usage.
REQ-004 SHALL have port exe_busy_i  in  1  EXE holding a multicycle op (mul/div/mem).
REQ-005 SHALL have ports wb_valid_i in 1, wb_we_i in 1, wb_rd_i in 5: write-back this cycle.
REQ-006 SHALL have ports branch_taken_i in 1 (EXE resolved redirect), xcpt_i in 1 (EXE exception).
REQ-007 SHALL have outputs stall_if_o, stall_id_o, stall_rr_o, stall_exe_o (1 each): hold pipeline registers.
REQ-008 SHALL have output flush_o  1  invalidate IF/ID/RR registers.
REQ-009 SHALL have output issue_o  1  RR instruction enters EXE this cycle.
REQ-010 SHALL have output next_pc_sel_o  2  00 PC+4, 01 branch target, 10 exception vector, 11 hold PC.
REQ-011 SHALL have output stall_cycles_o  32  performance counter.

Function
REQ-012 SHALL keep a 32-bit pending-write scoreboard; bit 0 (x0) always 0.
REQ-013 SHALL set pend[rr_rd_i] on issue_o & rr_we_i & rr_rd_i!=0; SHALL clear pend[wb_rd_i] on wb_valid_i & wb_we_i.
REQ-014 Same register set and cleared in one cycle: set SHALL win.
REQ-015 hazard = rr_valid_i & ((rr_use_rs1_i & pend[rr_rs1_i]) | (rr_use_rs2_i & pend[rr_rs2_i])), combinational.
REQ-016 FSM states RUN, DRAIN, REDIRECT; reset state RUN.
REQ-017 RUN: issue_o = rr_valid_i & !hazard & !exe_busy_i & !branch_taken_i & !xcpt_i.
REQ-018 RUN: stall_if_o=stall_id_o=stall_rr_o = rr_valid_i & (hazard | exe_busy_i) & !branch_taken_i; stall_exe_o = exe_busy_i in all states.
REQ-019 RUN & branch_taken_i & !xcpt_i: same cycle next_pc_sel_o=01, flush_o=1, front stalls 0; stay RUN.
REQ-020 RUN & xcpt_i: exe_busy_i=1 -> DRAIN, else -> REDIRECT; next_pc_sel_o=11 that cycle; xcpt_i SHALL take priority over branch_taken_i.
REQ-021 DRAIN: front stalls 1, issue_o 0, next_pc_sel_o=11; -> REDIRECT when exe_busy_i=0.
REQ-022 REDIRECT (exactly 1 cycle): next_pc_sel_o=10, flush_o=1, front stalls 0, issue_o 0; -> RUN.
REQ-023 branch_taken_i and xcpt_i SHALL be ignored in DRAIN and REDIRECT.
REQ-024 Otherwise next_pc_sel_o=00, flush_o=0.
REQ-025 stall_cycles_o SHALL increment each cycle stall_rr_o=1, saturating at 32'hFFFF_FFFF.
REQ-026 Write-back SHALL update the scoreboard in every state, including DRAIN and REDIRECT.

Reset
REQ-027 On rstn_i low (asynchronous): scoreboard 0, state RUN, stall_cycles_o 0.
REQ-028 Combinational outputs SHALL then follow RUN rules; with all inputs 0, all outputs 0 and next_pc_sel_o=00.
REQ-029 Reset mid-DRAIN SHALL return to RUN with no REDIRECT cycle.

Configuration
REQ-030 Macro PIPECTRL_WB_BYPASS_EN defined: in REQ-015 a source SHALL not count as pending if wb_valid_i & wb_we_i & wb_rd_i equals it (regfile write-through).
REQ-031 Macro undefined: REQ-015 SHALL use pend[] only; the RAW stall lasts one cycle longer.

Verification
REQ-032 Issue rd=x5 we; next cycle rr_rs1=x5 use_rs1 -> stall_rr_o=1, issue_o=0; wb rd=x5 -> issue next cycle (same cycle with PIPECTRL_WB_BYPASS_EN); stall_cycles_o advances.
REQ-033 rr_rs1=x0 use_rs1 after issue with rd=x0 we -> no stall; pend[0] stays 0.
REQ-034 branch_taken_i=1 in RUN with rr_valid_i hazard -> flush_o=1, next_pc_sel_o=01, stalls 0, issue_o 0, same cycle.
REQ-035 xcpt_i=1 with exe_busy_i=1 for 3 cycles -> 3 DRAIN cycles (next_pc_sel_o=11), then 1 cycle next_pc_sel_o=10 + flush_o=1, then RUN.
REQ-036 xcpt_i & branch_taken_i same cycle, exe_busy_i=0 -> REDIRECT next cycle, next_pc_sel_o never 01.
REQ-037 Preload stall_cycles_o to 32'hFFFF_FFFE, hold stall 3 cycles -> 32'hFFFF_FFFF, no wrap; rstn_i low mid-DRAIN -> RUN, counter 0.
